// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-edge detect and mid-bit sampling
module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       po_err,
    output logic       rx_busy
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF = BAUD_CNT_MAX / 2;
    localparam int CW = $clog2(BAUD_CNT_MAX);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_q, state_d;
    logic r1_q, r2_q, r3_q;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, po_data_q, po_data_d;
    logic po_flag_q, po_flag_d, po_err_q, po_err_d;
    logic start_edge, sample;

    assign start_edge = r3_q & ~r2_q;
    assign sample = baud_cnt_q == CW'(HALF);
    assign po_data = po_data_q;
    assign po_flag = po_flag_q;
    assign po_err = po_err_q;
    assign rx_busy = state_q != IDLE;

    // Three-stage synchroniser for the asynchronous pin; resets to the idle level
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r1_q <= 1'b1;
            r2_q <= 1'b1;
            r3_q <= 1'b1;
        end else begin
            r1_q <= rx;
            r2_q <= r1_q;
            r3_q <= r2_q;
        end
    end

    // Receiver state, bit timing and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            po_data_q  <= '0;
            po_flag_q  <= 1'b0;
            po_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            po_data_q  <= po_data_d;
            po_flag_q  <= po_flag_d;
            po_err_q   <= po_err_d;
        end
    end

    // Next state: baud counter idles at zero so every frame samples HALF clocks after the start edge
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = (state_q == IDLE || baud_cnt_q == CW'(BAUD_CNT_MAX - 1)) ? '0 : baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        po_data_d  = po_data_q;
        po_flag_d  = 1'b0;
        po_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (sample) begin
                    state_d   = r2_q ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {r2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_d   = IDLE;
                    po_flag_d = r2_q;
                    po_err_d  = ~r2_q;
                    po_data_d = r2_q ? shift_q : po_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-written and randomized frame checks for uart_rx
module tb_uart_rx;
    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 2_500_000;
    localparam int B = CLK_FREQ / UART_BPS;
    localparam int H = B / 2;
    localparam int LAT = 9 * B + H + 4;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_flag;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic rx = 1'b1;
    logic [7:0] po_data;
    logic po_flag, po_err, rx_busy;

    uart_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .rx(rx),
        .po_data(po_data),
        .po_flag(po_flag),
        .po_err(po_err),
        .rx_busy(rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_flag = 0, n_err = 0, n_both = 0, n_wide = 0;
    logic prev_flag = 1'b0;
    always @(negedge sys_clk) begin
        if (po_flag === 1'b1) n_flag <= n_flag + 1;
        if (po_err === 1'b1) n_err <= n_err + 1;
        if (po_flag === 1'b1 && po_err === 1'b1) n_both <= n_both + 1;
        if (po_flag === 1'b1 && prev_flag === 1'b1) n_wide <= n_wide + 1;
        prev_flag <= po_flag;
    end

    int n_cmp = 0, n_bad = 0;
    int s_flag = 0, s_err = 0;
    logic [7:0] last_good = 8'h00;
    vec_t tbl[7];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(d[i], B);
        hold(stop, B);
        if (gap_bits > 0) hold(1'b1, gap_bits * B);
    endtask

    task automatic snap();
        s_flag = n_flag;
        s_err = n_err;
    endtask

    task automatic check_frame(input string name, input int exp_flag, input int exp_err, input logic [7:0] exp_data);
        chk({name, " flag count"}, n_flag - s_flag, exp_flag);
        chk({name, " err count"}, n_err - s_err, exp_err);
        chk({name, " po_data"}, int'(po_data), int'(exp_data));
        snap();
    endtask

    initial begin
        #(200_000 * 20);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cyc, lat, t0;
        logic [7:0] d;
        logic stop;
        int gap;
        tbl[0] = '{8'h55, 1'b1, 2, 1, 0, 8'h55};
        tbl[1] = '{8'hA3, 1'b1, 2, 1, 0, 8'hA3};
        tbl[2] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        tbl[4] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
        tbl[5] = '{8'h80, 1'b1, 2, 1, 0, 8'h80};
        tbl[6] = '{8'h3C, 1'b0, 0, 0, 1, 8'h80};

        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("reset po_data", int'(po_data), 0);
        chk("reset po_flag", int'(po_flag), 0);
        chk("reset po_err", int'(po_err), 0);
        chk("reset rx_busy", int'(rx_busy), 0);
        hold(1'b1, 2 * B);
        snap();

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap);
            check_frame($sformatf("vec%0d", i), tbl[i].exp_flag, tbl[i].exp_err, tbl[i].exp_data);
        end
        last_good = 8'h80;

        hold(1'b0, 20 * B);
        check_frame("break hold", 0, 0, last_good);
        chk("break rx_busy", int'(rx_busy), 0);
        hold(1'b1, 2 * B);
        send_frame(8'h96, 1'b1, 2);
        last_good = 8'h96;
        check_frame("after break", 1, 0, last_good);

        busy_cyc = 0;
        rx = 1'b0;
        for (int i = 0; i < 3 * B; i++) begin
            if (i == B / 4) rx = 1'b1;
            @(posedge sys_clk);
            #1;
            if (rx_busy === 1'b1) busy_cyc++;
        end
        chk("glitch busy window", (busy_cyc >= H && busy_cyc <= H + 2) ? H + 1 : busy_cyc, H + 1);
        check_frame("glitch", 0, 0, last_good);

        fork
            send_frame(8'hC6, 1'b1, 0);
            begin
                repeat (5 * B + H) begin
                    @(posedge sys_clk);
                    #1;
                end
                sys_rst = 1'b1;
                @(posedge sys_clk);
                #1;
                sys_rst = 1'b0;
                chk("midframe reset po_data", int'(po_data), 0);
                chk("midframe reset po_flag", int'(po_flag), 0);
                chk("midframe reset po_err", int'(po_err), 0);
                chk("midframe reset rx_busy", int'(rx_busy), 0);
            end
        join
        check_frame("reset frame", 0, 0, 8'h00);
        hold(1'b1, 8 * B);
        snap();
        send_frame(8'h7E, 1'b1, 2);
        last_good = 8'h7E;
        check_frame("post reset", 1, 0, last_good);

        lat = -1;
        fork
            send_frame(8'h5A, 1'b1, 2);
            begin
                t0 = cyc;
                for (int i = 0; i < 12 * B; i++) begin
                    @(negedge sys_clk);
                    if (po_flag === 1'b1) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
        last_good = 8'h5A;
        check_frame("latency frame", 1, 0, last_good);

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(d, stop, gap);
            if (stop) last_good = d;
            check_frame($sformatf("rand%0d", i), stop ? 1 : 0, stop ? 0 : 1, last_good);
        end
        hold(1'b1, 2 * B);

        chk("flag and err together", n_both, 0);
        chk("flag wider than 1 cycle", n_wide, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
